// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode, state and datapath-select encodings shared with the ALU control circuit
package ctrl_pkg;
  localparam logic [3:0] OP_R    = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_LW   = 4'd2;
  localparam logic [3:0] OP_SW   = 4'd3;
  localparam logic [3:0] OP_BEQ  = 4'd4;
  localparam logic [3:0] OP_J    = 4'd5;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRC_B_RT  = 2'b00;
  localparam logic [1:0] SRC_B_ONE = 2'b01;
  localparam logic [1:0] SRC_B_IMM = 2'b10;
  localparam logic [1:0] SRC_B_BR  = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
    EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP
  } state_t;
endpackage

// File: rtl/retire_counter.sv
// retire_counter: 16-bit wrapping count of retired instructions
module retire_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (inc) count <= count + 16'd1;
endmodule

// File: rtl/multicycle_main_control.sv
// multicycle_main_control: opcode-driven FSM producing all multi-cycle datapath strobes
module multicycle_main_control
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  opcode,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic [1:0]  pc_source,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  ALUopt,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        illegal_op,
  output logic [15:0] retired_count
);
  state_t state, next;
  logic [3:0] op_q;
  logic inc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= FETCH;
      op_q <= OP_R;
    end else begin
      state <= next;
      if (state == DECODE) op_q <= opcode;
    end
  always_comb begin
    next = state;
    inc = 1'b0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    i_or_d = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    pc_source = PC_ALU;
    alu_src_a = 1'b0;
    alu_src_b = SRC_B_RT;
    ALUopt = ALU_ADD;
    reg_write = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    illegal_op = 1'b0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        alu_src_b = SRC_B_ONE;
        ir_write = mem_ready;
        pc_write = mem_ready;
        next = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = SRC_B_BR;
        case (opcode)
          OP_R:         next = EXEC_R;
          OP_ADDI:      next = EXEC_I;
          OP_LW, OP_SW: next = MEM_ADDR;
          OP_BEQ:       next = BRANCH;
          OP_J:         next = JUMP;
          default: begin
            illegal_op = 1'b1;
            next = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        next = (op_q == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        i_or_d = 1'b1;
        next = mem_ready ? MEM_WB : MEM_RD;
      end
      MEM_WB: begin
        reg_write = 1'b1;
        mem_to_reg = 1'b1;
        inc = 1'b1;
        next = FETCH;
      end
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we = 1'b1;
        i_or_d = 1'b1;
        inc = mem_ready;
        next = mem_ready ? FETCH : MEM_WR;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        ALUopt = ALU_FUNCT;
        next = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst = 1'b1;
        inc = 1'b1;
        next = FETCH;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        next = I_WB;
      end
      I_WB: begin
        reg_write = 1'b1;
        inc = 1'b1;
        next = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        ALUopt = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source = PC_ALUOUT;
        inc = 1'b1;
        next = FETCH;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_source = PC_JUMP;
        inc = 1'b1;
        next = FETCH;
      end
      default: next = FETCH;
    endcase
    if (rst) begin
      inc = 1'b0;
      mem_req = 1'b0;
      mem_we = 1'b0;
      i_or_d = 1'b0;
      ir_write = 1'b0;
      pc_write = 1'b0;
      pc_write_cond = 1'b0;
      pc_source = PC_ALU;
      alu_src_a = 1'b0;
      alu_src_b = SRC_B_RT;
      ALUopt = ALU_ADD;
      reg_write = 1'b0;
      reg_dst = 1'b0;
      mem_to_reg = 1'b0;
      illegal_op = 1'b0;
    end
  end
  retire_counter u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(inc),
    .count(retired_count)
  );
endmodule

// File: tb/tb_multicycle_main_control.sv
// tb_multicycle_main_control: scoreboard bench comparing per-cycle strobes and retire count
module tb_multicycle_main_control;
  logic clk, rst, mem_ready;
  logic [3:0] opcode;
  logic mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_source, alu_src_b, ALUopt;
  logic alu_src_a, reg_write, reg_dst, mem_to_reg, illegal_op;
  logic [15:0] retired_count;
  typedef struct packed {
    logic mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_source;
    logic alu_src_a;
    logic [1:0] alu_src_b, aluopt;
    logic reg_write, reg_dst, mem_to_reg, illegal_op;
  } outs_t;
  outs_t obs;
  int n_tests = 0;
  int n_fail = 0;
  logic [15:0] cnt;
  bit rdy_q[$];
  logic [3:0] opc_q[$];
  outs_t exp_q[$];
  string tag_q[$];
  multicycle_main_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALUopt(ALUopt),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal_op(illegal_op), .retired_count(retired_count)
  );
  assign obs = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
                alu_src_a, alu_src_b, ALUopt, reg_write, reg_dst, mem_to_reg, illegal_op};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic outs_t mk(int req, int we, int iod, int irw, int pcw, int pwc, int pcs,
                               int a, int b, int al, int rw, int rd, int m2r, int ill);
    return {req[0], we[0], iod[0], irw[0], pcw[0], pwc[0], pcs[1:0],
            a[0], b[1:0], al[1:0], rw[0], rd[0], m2r[0], ill[0]};
  endfunction
  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction
  task automatic push(input string tag, input bit rdy, input logic [3:0] op, input outs_t e);
    tag_q.push_back(tag);
    rdy_q.push_back(rdy);
    opc_q.push_back(op);
    exp_q.push_back(e);
  endtask
  task automatic issue(input logic [3:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) push("fetch_wait", 1'b0, 4'hE, mk(1,0,0,0,0,0,0,0,1,0,0,0,0,0));
    push("fetch_rdy", 1'b1, 4'hE, mk(1,0,0,1,1,0,0,0,1,0,0,0,0,0));
    push("decode", rnd(), op, mk(0,0,0,0,0,0,0,0,3,0,0,0,0, int'(op > 4'd5)));
    case (op)
      4'd0: begin
        push("exec_r", rnd(), 4'hE, mk(0,0,0,0,0,0,0,1,0,2,0,0,0,0));
        push("r_wb", rnd(), 4'hE, mk(0,0,0,0,0,0,0,0,0,0,1,1,0,0));
      end
      4'd1: begin
        push("exec_i", rnd(), 4'hE, mk(0,0,0,0,0,0,0,1,2,0,0,0,0,0));
        push("i_wb", rnd(), 4'hE, mk(0,0,0,0,0,0,0,0,0,0,1,0,0,0));
      end
      4'd2: begin
        push("mem_addr_lw", rnd(), 4'hE, mk(0,0,0,0,0,0,0,1,2,0,0,0,0,0));
        for (int i = 0; i < mw; i++) push("mem_rd_wait", 1'b0, 4'hE, mk(1,0,1,0,0,0,0,0,0,0,0,0,0,0));
        push("mem_rd_rdy", 1'b1, 4'hE, mk(1,0,1,0,0,0,0,0,0,0,0,0,0,0));
        push("mem_wb", rnd(), 4'hE, mk(0,0,0,0,0,0,0,0,0,0,1,0,1,0));
      end
      4'd3: begin
        push("mem_addr_sw", rnd(), 4'hE, mk(0,0,0,0,0,0,0,1,2,0,0,0,0,0));
        for (int i = 0; i < mw; i++) push("mem_wr_wait", 1'b0, 4'hE, mk(1,1,1,0,0,0,0,0,0,0,0,0,0,0));
        push("mem_wr_rdy", 1'b1, 4'hE, mk(1,1,1,0,0,0,0,0,0,0,0,0,0,0));
      end
      4'd4: push("branch", rnd(), 4'hE, mk(0,0,0,0,0,1,1,1,0,1,0,0,0,0));
      4'd5: push("jump", rnd(), 4'hE, mk(0,0,0,0,1,0,2,0,0,0,0,0,0,0));
      default: ;
    endcase
    if (op <= 4'd5) cnt = cnt + 16'd1;
  endtask
  task automatic drain();
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front();
      opcode = opc_q.pop_front();
      #2 check(tag_q.pop_front(), 32'(obs), 32'(exp_q.pop_front()));
      @(negedge clk);
    end
  endtask
  task automatic run(input logic [3:0] op, input int fw, input int mw);
    issue(op, fw, mw);
    drain();
    check("retired_count", 32'(retired_count), 32'(cnt));
  endtask
  initial begin
    rst = 1'b1;
    mem_ready = 1'b1;
    opcode = 4'd0;
    cnt = '0;
    @(negedge clk);
    @(negedge clk);
    #2 check("rst_outs", 32'(obs), 32'd0);
    check("rst_count", 32'(retired_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run(4'd0, 0, 0);
    run(4'd2, 2, 1);
    run(4'd4, 0, 0);
    run(4'd5, 0, 0);
    run(4'hF, 0, 0);
    run(4'd1, 1, 0);
    run(4'd3, 1, 2);
    run(4'd2, 0, 0);
    run(4'd6, 2, 0);
    run(4'd3, 0, 0);
    push("fetch_rdy", 1'b1, 4'hE, mk(1,0,0,1,1,0,0,0,1,0,0,0,0,0));
    push("decode", 1'b1, 4'd2, mk(0,0,0,0,0,0,0,0,3,0,0,0,0,0));
    push("mem_addr_lw", 1'b1, 4'hE, mk(0,0,0,0,0,0,0,1,2,0,0,0,0,0));
    push("mem_rd_wait", 1'b0, 4'hE, mk(1,0,1,0,0,0,0,0,0,0,0,0,0,0));
    drain();
    rst = 1'b1;
    mem_ready = 1'b1;
    cnt = '0;
    #2 check("midrst_outs", 32'(obs), 32'd0);
    check("midrst_count", 32'(retired_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run(4'd0, 0, 0);
    force dut.u_cnt.count = 16'hFFFF;
    #1 release dut.u_cnt.count;
    cnt = 16'hFFFF;
    run(4'd5, 0, 0);
    run(4'd5, 1, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
